// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Decodes the mem[] control field and gates every side-effecting output with out_valid.
module ex_mem_skid_stage #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       ILEN      = 32,
  parameter int unsigned       WB_W      = 2,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [ILEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             zero,
  input  logic [WB_W-1:0]  write_back,
  input  logic [2:0]       mem,
  input  logic [XLEN-1:0]  pc_adder,
  input  logic [XLEN-1:0]  alu_output,
  input  logic [XLEN-1:0]  rd2,
  input  logic [ILEN-1:0]  instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             zero_out,
  output logic             branch_taken,
  output logic [WB_W-1:0]  wb_out,
  output logic [XLEN-1:0]  pc_adder_out,
  output logic [XLEN-1:0]  alu,
  output logic [XLEN-1:0]  rd2_out,
  output logic [ILEN-1:0]  instr_out,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic            zero;
    logic [WB_W-1:0] wb;
    logic [2:0]      mem;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rd2;
    logic [ILEN-1:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  entry_t           main_q, skid_q, in_entry;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, deliver;
  logic             load_main_in, load_main_skid, load_skid;

  assign in_entry = '{zero:  zero,
                      wb:    write_back,
                      mem:   mem,
                      pc:    pc_adder,
                      alu:   alu_output,
                      rd2:   rd2,
                      instr: instr};

  // in_ready depends only on the registered state, never on out_ready.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (deliver) begin
          state_d = EMPTY;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end
      end
      FULL: begin
        if (deliver) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops any same-cycle accept; a same-cycle delivery has already happened.
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in)   main_q <= in_entry;
      if (load_main_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_entry;
      if (out_valid && !out_ready && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign branch       = out_valid & main_q.mem[0];
  assign mem_write    = out_valid & main_q.mem[1];
  assign mem_read     = out_valid & main_q.mem[2];
  assign zero_out     = out_valid & main_q.zero;
  assign branch_taken = branch & zero_out;
  assign wb_out       = out_valid ? main_q.wb : '0;
  assign pc_adder_out = main_q.pc;
  assign alu          = main_q.alu;
  assign rd2_out      = main_q.rd2;
  assign instr_out    = out_valid ? main_q.instr : NOP_INSTR;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: a monitor scoreboard checks every delivery in
// order, while the stimulus thread checks handshake, flush, branch and counter corners.
module tb_ex_mem_skid_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned WB_W  = 2;
  localparam int unsigned CNT_W = 4;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             reset_n, flush, in_valid, in_ready, zero, out_valid, out_ready;
  logic [WB_W-1:0]  write_back, wb_out;
  logic [2:0]       mem;
  logic [XLEN-1:0]  pc_adder, alu_output, rd2, pc_adder_out, alu, rd2_out;
  logic [ILEN-1:0]  instr, instr_out;
  logic             branch, mem_read, mem_write, zero_out, branch_taken;
  logic [CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [XLEN-1:0] alu, pc, rd2;
    logic [ILEN-1:0] instr;
    logic [5+WB_W-1:0] ctl;
  } exp_t;
  exp_t sb[$];

  ex_mem_skid_stage #(.XLEN(XLEN), .ILEN(ILEN), .WB_W(WB_W), .CNT_W(CNT_W),
                      .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .zero(zero), .write_back(write_back), .mem(mem), .pc_adder(pc_adder),
    .alu_output(alu_output), .rd2(rd2), .instr(instr), .out_valid(out_valid),
    .out_ready(out_ready), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .zero_out(zero_out), .branch_taken(branch_taken), .wb_out(wb_out),
    .pc_adder_out(pc_adder_out), .alu(alu), .rd2_out(rd2_out), .instr_out(instr_out),
    .stall_count(stall_count));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [XLEN-1:0] a, input logic [2:0] m,
                        input logic z);
    in_valid   = v;
    alu_output = a;
    pc_adder   = a + 32'h1000;
    rd2        = ~a;
    write_back = a[1:0];
    mem        = m;
    zero       = z;
    instr      = {a[15:0], 16'h0033};
  endtask

  // Present one instruction from a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [XLEN-1:0] a, input logic [2:0] m, input logic z);
    set_in(1'b1, a, m, z);
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed 0 for alu=%0h", a);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_instr_out", instr_out, NOP);
    check("rst_in_ready",  in_ready, 1);
    check("rst_mem_write", mem_write, 0);
    check("rst_alu",       alu, 0);
    check("rst_stall",     stall_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: samples just before each rising edge.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got alu %0h expected no delivery", alu);
        end else begin
          e = sb.pop_front();
          check("sb_alu",   alu, e.alu);
          check("sb_pc",    pc_adder_out, e.pc);
          check("sb_rd2",   rd2_out, e.rd2);
          check("sb_instr", instr_out, e.instr);
          check("sb_ctl",   {branch, mem_read, mem_write, zero_out, branch_taken, wb_out}, e.ctl);
        end
      end else if (!out_valid) begin
        check("bubble_instr", instr_out, NOP);
        check("bubble_ctl", {branch, mem_read, mem_write, zero_out, branch_taken, wb_out}, 0);
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e.alu   = alu_output;
        e.pc    = alu_output + 32'h1000;
        e.rd2   = ~alu_output;
        e.instr = {alu_output[15:0], 16'h0033};
        e.ctl   = {mem[0], mem[2], mem[1], zero, mem[0] & zero, alu_output[1:0]};
        sb.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, '0, 3'b000, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset with an entry in flight
    send(32'hAA, 3'b010, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    do_reset();

    // Streaming: one instruction per cycle, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(i, 3'b100, 1'b0);
      check("stream_valid", out_valid, 1);
      check("stream_alu", alu, i);
    end
    @(negedge clk);
    check("stream_drained", out_valid, 0);

    // Back-pressure: fill both entries, then release
    do_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h10, 3'b000, 1'b0);
    @(negedge clk); set_in(1'b1, 32'h11, 3'b000, 1'b0);
    @(negedge clk); set_in(1'b1, 32'h12, 3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("bp_stall3",   stall_count, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_head",     alu, 32'h10);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_again", in_ready, 1);
    check("bp_second",      alu, 32'h11);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_third", alu, 32'h12);
    @(negedge clk);
    check("bp_drained",    out_valid, 0);
    check("bp_stall_kept", stall_count, 3);

    // Flush from FULL with a simultaneous valid input
    do_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h40, 3'b010, 1'b0);
    @(negedge clk); set_in(1'b1, 32'h41, 3'b010, 1'b0);
    @(negedge clk);
    #1;
    check("fl_full",     in_ready, 0);
    check("fl_mw_valid", mem_write, 1);
    set_in(1'b1, 32'h42, 3'b010, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_out_valid", out_valid, 0);
    check("fl_mem_write", mem_write, 0);
    check("fl_in_ready",  in_ready, 1);
    check("fl_instr",     instr_out, NOP);
    out_ready = 1'b1;
    @(negedge clk);
    send(32'h43, 3'b110, 1'b1);
    check("fl_after", alu, 32'h43);
    @(negedge clk);

    // Branch qualification
    send(32'h20, 3'b001, 1'b1);
    check("br_taken",  branch_taken, 1);
    check("br_branch", branch, 1);
    send(32'h21, 3'b001, 1'b0);
    check("br_not_taken", branch_taken, 0);
    check("br_branch2",   branch, 1);
    @(negedge clk);
    check("br_bubble",  branch, 0);
    check("br_bubble2", branch_taken, 0);

    // Stall counter saturation
    do_reset();
    out_ready = 1'b0;
    send(32'h30, 3'b000, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("sat_F", stall_count, 4'hF);
    repeat (3) @(negedge clk);
    #1;
    check("sat_hold", stall_count, 4'hF);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sat_drained", out_valid, 0);
    check("sat_after",   stall_count, 4'hF);
    check("sb_empty",    sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
